sakiz_change_dispenser: RTL and testbench
=========================================

Name: sakiz_change_dispenser

Overview:
Payout side of the gum vending machine coin path. It accepts a change amount in kuruş from the vending controller and drives the coin hopper, one coin at a time. It uses 10-kuruş (B) and 5-kuruş (A) coins, paid greedily, with a per-coin ack handshake, and tracks hopper inventory. Before any coin is released it checks that the full amount can be paid, so a partial payout never occurs.

Parameters:
AMT_W, 6, width of requested change amount (kuruş)
INV_W, 8, width of each coin inventory counter
INV_A_INIT, 20, 5-kuruş coins loaded at reset
INV_B_INIT, 20, 10-kuruş coins loaded at reset
ACK_TIMEOUT, 15, cycles to wait for hopper_ack (only with SAKIZ_ACK_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  1  change request present
req_amount  in  AMT_W  change in kuruş
req_ready  out  1  high only in IDLE
A_out  out  1  one-cycle pulse: release one 5-kuruş coin
B_out  out  1  one-cycle pulse: release one 10-kuruş coin
hopper_ack  in  1  hopper confirms the coin dropped
refill_a  in  1  pulse: one 5-kuruş coin added to hopper
refill_b  in  1  pulse: one 10-kuruş coin added
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: payout complete
err_short  out  1  one-cycle pulse: request rejected, nothing paid
inv_a  out  INV_W  current 5-kuruş inventory
inv_b  out  INV_W  current 10-kuruş inventory

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; rem=0; inv_a=INV_A_INIT; inv_b=INV_B_INIT.
  - A_out, B_out, done, err_short and busy are 0.
  - req_ready is 1 once rst=1.
- Reset mid-payout aborts immediately. No done/err is issued. Coins already released are not recounted.
- Outputs are Moore decodes of registered state.
- States and transitions:
  - IDLE: accept when req_valid & req_ready at edge T. Latch rem=req_amount and go to CHECK (T+1).
  - CHECK: feasibility test.
    - Fail if req_amount mod 5 != 0.
    - Otherwise nb = min(inv_b, rem/10). Fail if (rem - 10*nb) > 5*inv_a.
    - Fail -> ERR; pass -> SELECT.
  - SELECT:
    - rem==0 -> DONE.
    - rem>=10 and inv_b>0 -> PULSE with coin=B.
    - Otherwise -> PULSE with coin=A.
  - PULSE: assert A_out or B_out for exactly this cycle, then go to WAIT_ACK.
  - WAIT_ACK: hold until hopper_ack=1. On that edge, rem -= coin value, decrement the matching inventory, go to SELECT.
    - hopper_ack outside WAIT_ACK is ignored.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: err_short=1 for one cycle, then IDLE. Inventory is unchanged.
- Latency:
  - First coin pulse at T+3 (CHECK at T+1, SELECT at T+2, PULSE at T+3).
  - Each further coin takes 3 cycles plus ack wait.
  - req_amount=0 gives done at T+3 with no pulses.
- Inventory:
  - refill adds 1 and saturates at 2^INV_W-1.
  - Refill and dispense-decrement on the same edge apply both (net 0).
  - Refills are accepted in any state, including mid-payout.
  - The feasibility check uses inventory as sampled in CHECK. The greedy SELECT cannot fail afterwards, because inventory only grows during a payout apart from the coins being paid.
- Arithmetic:
  - rem has width AMT_W.
  - Internal products are widened to AMT_W+INV_W+4 bits with no truncation.
  - rem never underflows, because a coin is only chosen when rem >= its value.

Optional Feature:
SAKIZ_ACK_TIMEOUT_EN
- Defined:
  - A counter runs while in WAIT_ACK.
  - If ACK_TIMEOUT cycles pass with no hopper_ack, go to ERR and pulse err_short. rem is discarded and the unacked coin is not deducted from inventory.
  - The counter clears on entry to WAIT_ACK.
- Undefined: WAIT_ACK waits indefinitely. No counter logic is present.

Decomposition:
- Shared package sakiz_pkg holds:
  - the state enum (IDLE, CHECK, SELECT, PULSE, WAIT_ACK, DONE, ERR);
  - the coin values COIN_A_VAL=5 and COIN_B_VAL=10;
  - a coin-select type {COIN_A, COIN_B}.
- The vending controller also uses sakiz_pkg.
- One sub-module: sakiz_coin_inventory. It holds one instance per coin type, containing a saturating counter with init value, refill increment and dispense decrement.

Test Plan:
- req_amount=35 with default inventory:
  - B_out pulses 3 times, then A_out once, each after hopper_ack.
  - done follows; inv_b=17, inv_a=19; first pulse 3 cycles after accept.
- INV_A_INIT=2, INV_B_INIT=0, req_amount=15: err_short at T+2, no coin pulses, inventory stays 2/0.
- req_amount=7: err_short, no pulses. req_amount=0: done at T+3, no pulses.
- INV_B_INIT=1, INV_A_INIT=4, req_amount=25:
  - Exactly one B pulse, then three A pulses, then done.
  - Final inventory b=0, a=1.
- Reset and refill:
  - Drive rst=0 while in WAIT_ACK: outputs clear asynchronously and inventory returns to INIT.
  - Pulse refill_a on the same edge as a hopper_ack for coin A: inv_a unchanged.
- With SAKIZ_ACK_TIMEOUT_EN and no hopper_ack after a B pulse: err_short exactly ACK_TIMEOUT=15 cycles after WAIT_ACK entry, and inv_b is not decremented.

Source files
------------

// File: rtl/sakiz_pkg.sv
// Shared types and coin constants for the gum-machine coin path
// (used by the change dispenser and the vending controller).
package sakiz_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SELECT,
    PULSE,
    WAIT_ACK,
    DONE,
    ERR
  } state_e;

  typedef enum logic {
    COIN_A,
    COIN_B
  } coin_e;

  localparam int COIN_A_VAL = 5;
  localparam int COIN_B_VAL = 10;

  function automatic int coin_value(input coin_e coin);
    return (coin == COIN_B) ? COIN_B_VAL : COIN_A_VAL;
  endfunction

endpackage

// File: rtl/sakiz_change_dispenser_if.sv
// Request/hopper/inventory bundle between the vending controller (master)
// and the change dispenser (slave).
interface sakiz_change_dispenser_if #(
  parameter int AMT_W = 6,
  parameter int INV_W = 8
) ();

  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             A_out;
  logic             B_out;
  logic             hopper_ack;
  logic             refill_a;
  logic             refill_b;
  logic             busy;
  logic             done;
  logic             err_short;
  logic [INV_W-1:0] inv_a;
  logic [INV_W-1:0] inv_b;

  modport master (
    output req_valid, req_amount, hopper_ack, refill_a, refill_b,
    input  req_ready, A_out, B_out, busy, done, err_short, inv_a, inv_b
  );

  modport slave (
    input  req_valid, req_amount, hopper_ack, refill_a, refill_b,
    output req_ready, A_out, B_out, busy, done, err_short, inv_a, inv_b
  );

endinterface

// File: rtl/sakiz_coin_inventory.sv
// Saturating per-coin inventory counter: loads INIT on reset, +1 on refill,
// -1 on dispense; both on the same edge cancel out.
module sakiz_coin_inventory #(
  parameter int INV_W = 8,
  parameter int INIT  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             refill_i,
  input  logic             dispense_i,
  output logic [INV_W-1:0] count_o
);

  logic [INV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (refill_i && !dispense_i) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (dispense_i && !refill_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= INV_W'(INIT);
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/sakiz_change_dispenser.sv
// Greedy 10/5-kurus change payout with up-front feasibility check and per-coin
// hopper ack. Optional hopper ack timeout: define SAKIZ_ACK_TIMEOUT_EN.
module sakiz_change_dispenser
  import sakiz_pkg::*;
#(
  parameter int AMT_W      = 6,
  parameter int INV_W      = 8,
  parameter int INV_A_INIT = 20,
  parameter int INV_B_INIT = 20
`ifdef SAKIZ_ACK_TIMEOUT_EN
  , parameter int ACK_TIMEOUT = 15
`endif
) (
  input logic                   clk,
  input logic                   rst,
  sakiz_change_dispenser_if.slave bus
);

  localparam int PW = AMT_W + INV_W + 4;
  localparam logic [PW-1:0] VAL_A_W = PW'(COIN_A_VAL);
  localparam logic [PW-1:0] VAL_B_W = PW'(COIN_B_VAL);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  coin_e            coin_q, coin_d;
  logic             dec_a, dec_b;
  logic [INV_W-1:0] inv_a, inv_b;

  logic [PW-1:0] rem_w, inv_a_w, inv_b_w, q10_w, nb_w, resid_w, cap_a_w;
  logic          feasible;

  // Feasibility: use as many B coins as stock allows, the rest must fit in A stock.
  always_comb begin
    rem_w    = PW'(rem_q);
    inv_a_w  = PW'(inv_a);
    inv_b_w  = PW'(inv_b);
    q10_w    = rem_w / VAL_B_W;
    nb_w     = (inv_b_w < q10_w) ? inv_b_w : q10_w;
    resid_w  = rem_w - nb_w * VAL_B_W;
    cap_a_w  = inv_a_w * VAL_A_W;
    feasible = ((rem_w % VAL_A_W) == '0) && (resid_w <= cap_a_w);
  end

`ifdef SAKIZ_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Held at zero outside WAIT_ACK, so every entry starts a fresh count.
  always_comb tmo_d = (state_q == WAIT_ACK) ? tmo_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    coin_d  = coin_q;
    dec_a   = 1'b0;
    dec_b   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rem_d   = bus.req_amount;
          state_d = CHECK;
        end
      end
      CHECK:  state_d = feasible ? SELECT : ERR;
      SELECT: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          coin_d  = (rem_w >= VAL_B_W && inv_b != '0) ? COIN_B : COIN_A;
          state_d = PULSE;
        end
      end
      PULSE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.hopper_ack) begin
          rem_d   = rem_q - AMT_W'(coin_value(coin_q));
          dec_a   = (coin_q == COIN_A);
          dec_b   = (coin_q == COIN_B);
          state_d = SELECT;
        end
`ifdef SAKIZ_ACK_TIMEOUT_EN
        else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          rem_d   = '0;
          state_d = ERR;
        end
`endif
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      coin_q  <= COIN_A;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coin_q  <= coin_d;
    end
  end

  sakiz_coin_inventory #(
    .INV_W (INV_W),
    .INIT  (INV_A_INIT)
  ) u_inv_a (
    .clk        (clk),
    .rst_n      (rst),
    .refill_i   (bus.refill_a),
    .dispense_i (dec_a),
    .count_o    (inv_a)
  );

  sakiz_coin_inventory #(
    .INV_W (INV_W),
    .INIT  (INV_B_INIT)
  ) u_inv_b (
    .clk        (clk),
    .rst_n      (rst),
    .refill_i   (bus.refill_b),
    .dispense_i (dec_b),
    .count_o    (inv_b)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.A_out     = (state_q == PULSE) && (coin_q == COIN_A);
  assign bus.B_out     = (state_q == PULSE) && (coin_q == COIN_B);
  assign bus.done      = (state_q == DONE);
  assign bus.err_short = (state_q == ERR);
  assign bus.inv_a     = inv_a;
  assign bus.inv_b     = inv_b;

endmodule

// File: tb/tb_sakiz_change_dispenser.sv
// Bench for sakiz_change_dispenser: directed payout/error/saturation/reset cases
// plus randomized requests and refills against a coin-level reference model.
module tb_sakiz_change_dispenser;

  localparam int AMT_W      = 6;
  localparam int INV_W      = 8;
  localparam int INV_A_INIT = 20;
  localparam int INV_B_INIT = 20;
  localparam int INV_MAX    = 255;
`ifdef SAKIZ_ACK_TIMEOUT_EN
  localparam int ACK_TIMEOUT = 15;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   m_a;
  int   m_b;

  sakiz_change_dispenser_if #(.AMT_W(AMT_W), .INV_W(INV_W)) bus ();

  sakiz_change_dispenser #(
    .AMT_W      (AMT_W),
    .INV_W      (INV_W),
    .INV_A_INIT (INV_A_INIT),
    .INV_B_INIT (INV_B_INIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < INV_MAX) ? v + 1 : INV_MAX;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req_valid  = 1'b0;
    bus.hopper_ack = 1'b0;
    bus.refill_a   = 1'b0;
    bus.refill_b   = 1'b0;
  endtask

  task automatic chk_inv(input string tag);
    chk({tag, "_inv_a"}, 32'(bus.inv_a), m_a);
    chk({tag, "_inv_b"}, 32'(bus.inv_b), m_b);
  endtask

  task automatic refill_cycles(input int n, input bit a, input bit b);
    for (int i = 0; i < n; i++) begin
      bus.refill_a = a;
      bus.refill_b = b;
      step();
      if (a) m_a = sat_inc(m_a);
      if (b) m_b = sat_inc(m_b);
      clear_inputs();
    end
  endtask

  // Idle cycles with random refills and stray acks (acks must be ignored).
  task automatic idle_gap();
    logic [2:0] r;
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      r = 3'($urandom);
      bus.refill_a   = r[0];
      bus.refill_b   = r[1];
      bus.hopper_ack = r[2];
      step();
      if (r[0]) m_a = sat_inc(m_a);
      if (r[1]) m_b = sat_inc(m_b);
      clear_inputs();
    end
    chk_inv("gap");
  endtask

  // One full request: accept, feasibility, then coin by coin until done/err.
  task automatic do_req(input int amt, input bit rnd, input bit ack_ref_a);
    int  rem, nb, d;
    bit  feas, exp_b;
    logic [1:0] r;
    chk("req_ready", 32'(bus.req_ready), 1);
    bus.req_valid  = 1'b1;
    bus.req_amount = AMT_W'(amt);
    step();
    bus.req_valid = 1'b0;
    chk("busy_check", 32'(bus.busy), 1);
    nb   = (m_b < amt / 10) ? m_b : amt / 10;
    feas = (amt % 5 == 0) && (amt - 10 * nb <= 5 * m_a);
    step();
    if (!feas) begin
      chk("err_short", 32'(bus.err_short), 1);
      chk("err_no_coin", 32'({bus.A_out, bus.B_out}), 0);
      chk("err_no_done", 32'(bus.done), 0);
      step();
      chk("err_one_cycle", 32'(bus.err_short), 0);
      chk("err_ready", 32'(bus.req_ready), 1);
      chk_inv("err");
      return;
    end
    chk("no_err", 32'(bus.err_short), 0);
    rem = amt;
    for (int coin = 0; coin < 20; coin++) begin
      step();
      if (rem == 0) begin
        chk("done", 32'(bus.done), 1);
        chk("done_no_coin", 32'({bus.A_out, bus.B_out}), 0);
        break;
      end
      exp_b = (rem >= 10) && (m_b > 0);
      chk("B_out", 32'(bus.B_out), 32'(exp_b));
      chk("A_out", 32'(bus.A_out), 32'(!exp_b));
      chk("no_done_mid", 32'(bus.done), 0);
      step();
      chk("pulse_width", 32'({bus.A_out, bus.B_out}), 0);
      d = rnd ? $urandom_range(0, 3) : 0;
      for (int i = 0; i < d; i++) begin
        r = 2'($urandom);
        bus.refill_a = r[0];
        bus.refill_b = r[1];
        step();
        if (r[0]) m_a = sat_inc(m_a);
        if (r[1]) m_b = sat_inc(m_b);
        clear_inputs();
        chk("wait_hold", 32'({bus.A_out, bus.B_out, bus.done}), 0);
      end
      bus.hopper_ack = 1'b1;
      bus.refill_a   = ack_ref_a;
      step();
      clear_inputs();
      rem -= exp_b ? 10 : 5;
      if (exp_b) m_b--;
      else       m_a--;
      if (ack_ref_a) m_a = sat_inc(m_a);
      chk_inv("ack");
    end
    step();
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("done_ready", 32'(bus.req_ready), 1);
  endtask

  // Accept a one-B-coin request and stop at the first WAIT_ACK cycle.
  task automatic go_wait_b10();
    chk("gw_ready", 32'(bus.req_ready), 1);
    bus.req_valid  = 1'b1;
    bus.req_amount = AMT_W'(10);
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    chk("gw_B_out", 32'(bus.B_out), 1);
    step();
    chk("gw_wait", 32'({bus.A_out, bus.B_out, bus.busy}), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_chk);
    $fatal(1);
  end

  initial begin
    int amt;
    n_chk  = 0;
    n_fail = 0;
    clear_inputs();
    bus.req_amount = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    m_a = INV_A_INIT;
    m_b = INV_B_INIT;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_pulses", 32'({bus.A_out, bus.B_out, bus.done, bus.err_short}), 0);
    chk_inv("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_ready", 32'(bus.req_ready), 1);

    // 35 -> B,B,B,A
    do_req(35, 0, 0);
    chk("p35_inv_b", 32'(bus.inv_b), 17);
    chk("p35_inv_a", 32'(bus.inv_a), 19);
    do_req(7, 0, 0);
    do_req(0, 0, 0);

    // Drain to b=1, a=4, then 25 must pay B + 3xA.
    for (int i = 0; i < 15; i++) do_req(5, 0, 0);
    do_req(60, 0, 0);
    do_req(60, 0, 0);
    do_req(40, 0, 0);
    chk("drain_inv_b", 32'(bus.inv_b), 1);
    chk("drain_inv_a", 32'(bus.inv_a), 4);
    do_req(25, 0, 0);
    chk("p25_inv_b", 32'(bus.inv_b), 0);
    chk("p25_inv_a", 32'(bus.inv_a), 1);
    do_req(15, 0, 0);
    chk("short_inv_a", 32'(bus.inv_a), 1);

    // Saturation, and refill on the same edge as an A-coin ack.
    refill_cycles(260, 1'b1, 1'b0);
    chk("sat_inv_a", 32'(bus.inv_a), INV_MAX);
    do_req(5, 0, 1);
    chk("net0_inv_a", 32'(bus.inv_a), INV_MAX);
    refill_cycles(3, 1'b0, 1'b1);
    chk_inv("refill");

    for (int i = 0; i < 40; i++) begin
      idle_gap();
      amt = ($urandom_range(0, 1) == 0) ? 5 * $urandom_range(0, 12) : $urandom_range(0, 63);
      do_req(amt, 1, 1'($urandom_range(0, 1)));
    end

`ifdef SAKIZ_ACK_TIMEOUT_EN
    refill_cycles(1, 1'b0, 1'b1);
    go_wait_b10();
    repeat (ACK_TIMEOUT - 1) step();
    chk("tmo_early", 32'(bus.err_short), 0);
    step();
    chk("tmo_err", 32'(bus.err_short), 1);
    chk_inv("tmo");
    step();
    chk("tmo_ready", 32'(bus.req_ready), 1);
`endif

    // Asynchronous reset in WAIT_ACK.
    refill_cycles(1, 1'b0, 1'b1);
    go_wait_b10();
    #2 rst = 1'b0;
    #1;
    m_a = INV_A_INIT;
    m_b = INV_B_INIT;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_pulses", 32'({bus.A_out, bus.B_out, bus.done, bus.err_short}), 0);
    chk_inv("arst");
    @(negedge clk);
    rst = 1'b1;
    chk("arst_ready", 32'(bus.req_ready), 1);
    step();
    do_req(35, 0, 0);
    chk("post_rst_inv_b", 32'(bus.inv_b), 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
